// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl
// Pointer and flag controller for a single-clock FIFO memory (32 x 8 by default).
// Owns the write/read pointers (binary, one extra wrap bit), derives the
// occupancy flags combinationally from them, and produces a read-data-valid
// strobe aligned to the memory's one-cycle read latency plus sticky
// overflow/underflow error flags.

module fifo_sync_ctrl #(
    parameter int DEPTH    = 32,
    parameter int WIDTH    = 5,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             flush,
    input  logic             clr_err,
    output logic [WIDTH:0]   waddr,
    output logic [WIDTH:0]   raddr,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [WIDTH:0]   count,
    output logic             rd_valid,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [WIDTH:0] PTR_ONE   = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] DEPTH_CNT = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0] AF_THR    = (WIDTH+1)'(AF_LEVEL);
    localparam logic [WIDTH:0] AE_THR    = (WIDTH+1)'(AE_LEVEL);

    logic [WIDTH:0] wptr;
    logic [WIDTH:0] rptr;
    logic           wr_acc;
    logic           rd_acc;

    assign waddr = wptr;
    assign raddr = rptr;

    // Occupancy flags straight from the registered pointers, so they are
    // valid in the same cycle the memory samples waddr/raddr. With
    // DEPTH == 2**WIDTH, count == DEPTH is exactly "wrap bits differ and
    // index bits match".
    always_comb begin
        count        = wptr - rptr;
        empty        = (wptr == rptr);
        full         = (count == DEPTH_CNT);
        almost_full  = (count >= AF_THR);
        almost_empty = (count <= AE_THR);
        wr_acc       = wr_en && !full;
        rd_acc       = rd_en && !empty;
    end

    // Pointer advance and read-valid strobe; flush overrides any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
        end else if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_acc) begin
                rptr <= rptr + PTR_ONE;
            end
            rd_valid <= rd_acc;
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins over clr_err,
    // and flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl
// Directed bench for fifo_sync_ctrl. A small 32 x 8 memory stand-in sits
// beside the controller so read data can be compared against a queue of
// written words; occupancy is tracked with a simple counter model.

module tb_fifo_sync_ctrl;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       flush;
    logic       clr_err;
    logic [5:0] waddr;
    logic [5:0] raddr;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] count;
    logic       rd_valid;
    logic       overflow;
    logic       underflow;

    logic [7:0] mem [32];
    logic [7:0] dout;
    logic [7:0] wdata;

    int         checks;
    int         failures;

    int         exp_count;
    int         exp_w;
    int         exp_r;
    bit         exp_ovf;
    bit         exp_udf;
    logic [7:0] sb [$];
    logic [7:0] next_data;

    fifo_sync_ctrl #(
        .DEPTH    (32),
        .WIDTH    (5),
        .AF_LEVEL (28),
        .AE_LEVEL (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .flush        (flush),
        .clr_err      (clr_err),
        .waddr        (waddr),
        .raddr        (raddr),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .rd_valid     (rd_valid),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: write gated by full, registered read gated by empty.
    always @(posedge clk) begin
        if (wr_en && !full) begin
            mem[waddr[4:0]] <= wdata;
        end
        if (rd_en && !empty) begin
            dout <= mem[raddr[4:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_count = 0;
        exp_w     = 0;
        exp_r     = 0;
        sb.delete();
    endtask

    // One clock cycle of wr/rd/clr_err, predicted from the counter model.
    task automatic op(input bit w, input bit r, input bit ce);
        bit         wacc;
        bit         racc;
        logic [7:0] ed;
        wacc = w && (exp_count < 32);
        racc = r && (exp_count > 0);
        ed   = 8'h00;
        if (racc) ed = sb.pop_front();
        if (wacc) sb.push_back(next_data);
        exp_ovf   = (w && exp_count == 32) ? 1'b1 : (ce ? 1'b0 : exp_ovf);
        exp_udf   = (r && exp_count == 0)  ? 1'b1 : (ce ? 1'b0 : exp_udf);
        exp_count = exp_count + int'(wacc) - int'(racc);
        if (wacc) exp_w = (exp_w + 1) % 64;
        if (racc) exp_r = (exp_r + 1) % 64;
        wr_en   = w;
        rd_en   = r;
        clr_err = ce;
        wdata   = next_data;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        if (wacc) next_data = next_data + 8'd1;
        chk("count", count, exp_count);
        chk("full", full, (exp_count == 32));
        chk("empty", empty, (exp_count == 0));
        chk("almost_full", almost_full, (exp_count >= 28));
        chk("almost_empty", almost_empty, (exp_count <= 4));
        chk("waddr", waddr, exp_w);
        chk("raddr", raddr, exp_r);
        chk("rd_valid", rd_valid, racc);
        if (racc) chk("rd_data", dout, ed);
        chk("overflow", overflow, exp_ovf);
        chk("underflow", underflow, exp_udf);
    endtask

    task automatic goto_count(input int n);
        while (exp_count < n) op(1'b1, 1'b0, 1'b0);
        while (exp_count > n) op(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        flush     = 1'b0;
        clr_err   = 1'b0;
        wdata     = 8'h00;
        next_data = 8'h00;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle.
        for (int i = 0; i < 5; i++) op(1'b0, 1'b0, 1'b0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_raddr", raddr, 0);

        // Fill with 00..1F.
        for (int i = 0; i < 32; i++) begin
            op(1'b1, 1'b0, 1'b0);
            chk("fill_count", count, i + 1);
        end
        chk("fill_full", full, 1);
        chk("fill_waddr", waddr, 6'h20);
        chk("fill_af", almost_full, 1);

        // 33rd write is dropped and flags overflow.
        op(1'b1, 1'b0, 1'b0);
        chk("ovf_waddr", waddr, 6'h20);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 32);

        // Drain 32 words, expecting 00..1F in order.
        for (int i = 0; i < 32; i++) begin
            op(1'b0, 1'b1, 1'b0);
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", dout, i);
        end
        chk("drain_empty", empty, 1);

        // Read while empty: no valid, underflow set.
        op(1'b0, 1'b1, 1'b0);
        chk("udf_valid", rd_valid, 0);
        chk("udf_flag", underflow, 1);
        chk("udf_raddr", raddr, 6'h20);

        op(1'b0, 1'b0, 1'b1);
        chk("clr_ovf", overflow, 0);
        chk("clr_udf", underflow, 0);

        // Simultaneous at empty: write only, no fall-through.
        op(1'b1, 1'b1, 1'b0);
        chk("sim_empty_count", count, 1);
        chk("sim_empty_valid", rd_valid, 0);
        chk("sim_empty_waddr", waddr, 6'h21);
        op(1'b0, 1'b0, 1'b1);

        // Simultaneous at count 10: both pointers advance.
        goto_count(10);
        op(1'b1, 1'b1, 1'b0);
        chk("sim_mid_count", count, 10);
        chk("sim_mid_waddr", waddr, 6'h2B);
        chk("sim_mid_raddr", raddr, 6'h21);

        // Simultaneous at full: read only.
        goto_count(32);
        chk("sim_full_pre", full, 1);
        op(1'b1, 1'b1, 1'b0);
        chk("sim_full_count", count, 31);
        chk("sim_full_valid", rd_valid, 1);

        // Random stream; pointers wrap several times.
        for (int i = 0; i < 500; i++) begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Flush at count 7 with a pending underflow and an active read.
        goto_count(0);
        op(1'b0, 1'b1, 1'b0);
        goto_count(8);
        op(1'b0, 1'b1, 1'b0);
        chk("pre_flush_count", count, 7);
        flush = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_reset();
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_valid", rd_valid, 0);
        chk("flush_waddr", waddr, 0);
        chk("flush_udf_kept", underflow, 1);

        // clr_err coincident with a new overflow: set wins.
        goto_count(32);
        op(1'b0, 1'b0, 1'b1);
        chk("clr_only_ovf", overflow, 0);
        op(1'b1, 1'b0, 1'b1);
        chk("clr_vs_ovf", overflow, 1);

        // Async reset pulse between edges at count 7.
        goto_count(8);
        op(1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_waddr", waddr, 0);
        chk("arst_raddr", raddr, 0);
        chk("arst_ae", almost_empty, 1);
        #1 rst = 1'b0;
        model_reset();
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
        op(1'b1, 1'b0, 1'b0);
        op(1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
